fetch_queue: RTL

//  Parametrised instruction-fetch front end; replaces the bare PC register + adder_4 of the single-cycle core.

---
 rtl/fetch_queue_if.sv | 34 +++
 rtl/fetch_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction-memory read port, redirect input and decode-side valid/ready head.
// Latency: none (wires only).
// Backpressure: decode holds inst_ready_in low to stall the head entry.
interface fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req_out;
    logic [ADDR_W-1:0] imem_addr_out;
    logic [INST_W-1:0] imem_data_in;
    logic              redirect_in;
    logic [ADDR_W-1:0] redirect_pc_in;
    logic              inst_valid_out;
    logic              inst_ready_in;
    logic [INST_W-1:0] inst_out;
    logic [ADDR_W-1:0] inst_pc_out;
    logic [ADDR_W-1:0] inst_pcn_out;

    modport master (
        output imem_req_out, imem_addr_out,
        input  imem_data_in,
        input  redirect_in, redirect_pc_in,
        output inst_valid_out, inst_out, inst_pc_out, inst_pcn_out,
        input  inst_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out,
        output imem_data_in,
        output redirect_in, redirect_pc_in,
        input  inst_valid_out, inst_out, inst_pc_out, inst_pcn_out,
        output inst_ready_in
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, reads a 1-cycle sync ROM, buffers words in a DEPTH-entry queue.
// Latency: request to head-valid is 2 cycles; redirect to target at head is 3 cycles.
// Backpressure: requests stop while stored + in-flight reaches DEPTH; FETCH_PERF_CNT_EN adds perf counters.
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000)
) (
    input  logic          clock,
    input  logic          reset,
    fetch_queue_if.master fq
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetched_out,
    output logic [31:0]   perf_flushed_out
`endif
);
    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic [CNT_W-1:0]  occupancy;
    logic [ADDR_W-1:0] target_pc;
    logic              req, head_vld, push, pop;
    entry_t            head;

    // Occupancy counts the outstanding read so the queue can never overflow when it returns.
    always_comb begin
        target_pc = fq.redirect_pc_in & ~ADDR_W'(3);
        occupancy = count_q + CNT_W'(inflight_q);
        req       = reset & ~fq.redirect_in & (occupancy < FULL_CNT);
        head_vld  = (count_q != '0);
        pop       = head_vld & fq.inst_ready_in & ~fq.redirect_in;
        push      = inflight_q & ~fq.redirect_in;
        head      = head_vld ? mem_q[rd_ptr_q] : '0;
    end

    assign fq.imem_req_out   = req;
    assign fq.imem_addr_out  = pc_q;
    assign fq.inst_valid_out = head_vld;
    assign fq.inst_out       = head.inst;
    assign fq.inst_pc_out    = head.pc;
    assign fq.inst_pcn_out   = head.pc + PC_STEP;

    always_comb begin
        pc_d          = pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        mem_d         = mem_q;
        if (fq.redirect_in) begin
            // Drops stored entries and the read returning this cycle.
            pc_d     = target_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (req) begin
                pc_d          = pc_q + PC_STEP;
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{inst: fq.imem_data_in, pc: inflight_pc_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while the queue is empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(pop);
        perf_flushed_d = perf_flushed_q;
        if (fq.redirect_in) begin
            perf_flushed_d = perf_flushed_q + 32'(count_q) + 32'(inflight_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            perf_fetched_q <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_fetched_out = perf_fetched_q;
    assign perf_flushed_out = perf_flushed_q;
`endif
endmodule
